// File: rtl/rs_age_issue_pkg.sv
// Shared defaults, opcodes and boolean constants for the arithmetic/branch reservation station.
package rs_age_issue_pkg;

  localparam int DEPTH_DEF   = 16;
  localparam int IDX_W_DEF   = 4;
  localparam int ROB_W_DEF   = 4;
  localparam int XLEN_DEF    = 32;
  localparam int OP_W_DEF    = 6;
  localparam int NUM_CDB_DEF = 2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [OP_W_DEF-1:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_AND  = 6'd2,
    OP_OR   = 6'd3,
    OP_XOR  = 6'd4,
    OP_SLL  = 6'd5,
    OP_SRL  = 6'd6,
    OP_SRA  = 6'd7,
    OP_SLT  = 6'd8,
    OP_SLTU = 6'd9,
    OP_BEQ  = 6'd10,
    OP_BNE  = 6'd11,
    OP_BLT  = 6'd12,
    OP_BGE  = 6'd13,
    OP_JAL  = 6'd14,
    OP_JALR = 6'd15
  } op_e;

endpackage

// File: rtl/rs_age_picker.sv
// Age matrix (r_age[i][j]=1 means j is older than i) with oldest-eligible select and index encode.
module rs_age_picker
  import rs_age_issue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ins,
  input  logic [IDX_W-1:0] i_ins_idx,
  input  logic [DEPTH-1:0] i_valid,
  input  logic [DEPTH-1:0] i_elig,
  output logic [IDX_W-1:0] o_sel_idx,
  output logic             o_any
);

  logic [DEPTH-1:0] r_age [DEPTH];
  logic [DEPTH-1:0] w_sel_oh;

  // A new entry is younger than every current one; stale bits of freed slots are
  // harmless because a slot's column is cleared again when it is reused.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < DEPTH; r++) r_age[r] <= '0;
    end else if (i_ins) begin
      for (int r = 0; r < DEPTH; r++) begin
        if (IDX_W'(r) == i_ins_idx) r_age[r] <= i_valid;
        else                        r_age[r][i_ins_idx] <= FALSE;
      end
    end
  end

  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sel_oh[i] = i_elig[i] & ~(|(r_age[i] & i_elig));
    end
  end

  always_comb begin
    o_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel_oh[i]) o_sel_idx = o_sel_idx | IDX_W'(i);
    end
  end

  assign o_any = |i_elig;

endmodule

// File: rtl/rs_age_issue.sv
// Reservation station: single dispatch per cycle, CDB wakeup with same-cycle bypass,
// oldest-ready issue to the ALU under a valid/ready handshake.
module rs_age_issue
  import rs_age_issue_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int ROB_W   = ROB_W_DEF,
  parameter int XLEN    = XLEN_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int NUM_CDB = NUM_CDB_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_rdy,
  input  logic                     i_flush,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [OP_W-1:0]          i_in_op,
  input  logic [ROB_W-1:0]         i_in_rob,
  input  logic                     i_in_src1_rdy,
  input  logic                     i_in_src2_rdy,
  input  logic [XLEN-1:0]          i_in_val1,
  input  logic [XLEN-1:0]          i_in_val2,
  input  logic                     i_in_use_imm,
  input  logic [XLEN-1:0]          i_in_imm,
  input  logic [NUM_CDB-1:0]       i_cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] i_cdb_rob,
  input  logic [NUM_CDB*XLEN-1:0]  i_cdb_val,
  output logic                     o_iss_valid,
  input  logic                     i_iss_ready,
  output logic [OP_W-1:0]          o_iss_op,
  output logic [XLEN-1:0]          o_iss_val1,
  output logic [XLEN-1:0]          o_iss_val2,
  output logic [ROB_W-1:0]         o_iss_rob,
  output logic [IDX_W:0]           o_count,
  output logic                     o_full
);

  logic [DEPTH-1:0] r_valid, r_rdy1, r_rdy2;
  logic [IDX_W:0]   r_count;
  logic [OP_W-1:0]  r_op   [DEPTH];
  logic [ROB_W-1:0] r_rob  [DEPTH];
  logic [XLEN-1:0]  r_val1 [DEPTH];
  logic [XLEN-1:0]  r_val2 [DEPTH];

  logic             w_full, w_ins, w_deq, w_any;
  logic [IDX_W-1:0] w_free_idx, w_sel_idx;
  logic [DEPTH-1:0] w_elig, w_wk1_hit, w_wk2_hit;
  logic [XLEN-1:0]  w_wk1_val [DEPTH];
  logic [XLEN-1:0]  w_wk2_val [DEPTH];
  logic             w_byp1_hit, w_byp2_hit;
  logic [XLEN-1:0]  w_byp1_val, w_byp2_val;

  // Returns {hit, value}; scanning downwards lets the lowest channel win.
  function automatic logic [XLEN:0] cdb_match(
    input logic [ROB_W-1:0]         tag,
    input logic [NUM_CDB-1:0]       vld,
    input logic [NUM_CDB*ROB_W-1:0] rob,
    input logic [NUM_CDB*XLEN-1:0]  val
  );
    logic [XLEN:0] res;
    res = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (vld[c] && rob[c*ROB_W +: ROB_W] == tag) res = {TRUE, val[c*XLEN +: XLEN]};
    end
    return res;
  endfunction

  assign w_full     = (r_count == (IDX_W+1)'(DEPTH));
  assign o_in_ready = !w_full && i_rdy && !i_flush;
  assign w_ins      = i_in_valid && o_in_ready;
  assign o_count    = r_count;
  assign o_full     = w_full;

  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    {w_byp1_hit, w_byp1_val} = cdb_match(i_in_val1[ROB_W-1:0], i_cdb_valid, i_cdb_rob, i_cdb_val);
    {w_byp2_hit, w_byp2_val} = cdb_match(i_in_val2[ROB_W-1:0], i_cdb_valid, i_cdb_rob, i_cdb_val);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {w_wk1_hit[i], w_wk1_val[i]} = cdb_match(r_val1[i][ROB_W-1:0], i_cdb_valid, i_cdb_rob, i_cdb_val);
      {w_wk2_hit[i], w_wk2_val[i]} = cdb_match(r_val2[i][ROB_W-1:0], i_cdb_valid, i_cdb_rob, i_cdb_val);
      w_wk1_hit[i] = w_wk1_hit[i] & r_valid[i] & ~r_rdy1[i];
      w_wk2_hit[i] = w_wk2_hit[i] & r_valid[i] & ~r_rdy2[i];
    end
  end

  // Ready bits are registered, so an entry woken this cycle issues no earlier than next cycle.
  assign w_elig = r_valid & r_rdy1 & r_rdy2;

  rs_age_picker #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ins     (w_ins),
    .i_ins_idx (w_free_idx),
    .i_valid   (r_valid),
    .i_elig    (w_elig),
    .o_sel_idx (w_sel_idx),
    .o_any     (w_any)
  );

  assign o_iss_valid = w_any && i_rdy && !i_flush;
  assign w_deq       = o_iss_valid && i_iss_ready;
  assign o_iss_op    = r_op[w_sel_idx];
  assign o_iss_val1  = r_val1[w_sel_idx];
  assign o_iss_val2  = r_val2[w_sel_idx];
  assign o_iss_rob   = r_rob[w_sel_idx];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_rdy1  <= '0;
      r_rdy2  <= '0;
      r_count <= '0;
    end else if (i_rdy) begin
      if (i_flush) begin
        r_valid <= '0;
        r_count <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_wk1_hit[i]) r_rdy1[i] <= TRUE;
          if (w_wk2_hit[i]) r_rdy2[i] <= TRUE;
        end
        if (w_deq) r_valid[w_sel_idx] <= FALSE;
        if (w_ins) begin
          r_valid[w_free_idx] <= TRUE;
          r_rdy1[w_free_idx]  <= i_in_src1_rdy | w_byp1_hit;
          r_rdy2[w_free_idx]  <= i_in_use_imm | i_in_src2_rdy | w_byp2_hit;
        end
        r_count <= r_count + (IDX_W+1)'(w_ins) - (IDX_W+1)'(w_deq);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rdy && !i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wk1_hit[i]) r_val1[i] <= w_wk1_val[i];
        if (w_wk2_hit[i]) r_val2[i] <= w_wk2_val[i];
      end
      if (w_ins) begin
        r_op[w_free_idx]   <= i_in_op;
        r_rob[w_free_idx]  <= i_in_rob;
        r_val1[w_free_idx] <= (!i_in_src1_rdy && w_byp1_hit) ? w_byp1_val : i_in_val1;
        r_val2[w_free_idx] <= i_in_use_imm ? i_in_imm :
                              (!i_in_src2_rdy && w_byp2_hit) ? w_byp2_val : i_in_val2;
      end
    end
  end

endmodule
